// File: rtl/uart_rx_mon_if.sv
// Read-side handshake of uart_rx_mon: first-word fall-through head byte and its error flags.
interface uart_rx_mon_if;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic       rd_break;

    modport master (output rd_valid, rd_data, rd_perr, rd_ferr, rd_break, input rd_ready);
    modport slave  (input rd_valid, rd_data, rd_perr, rd_ferr, rd_break, output rd_ready);
endinterface

// File: rtl/uart_rx_mon.sv
// UART receive monitor: 16x oversampled deserialiser with parity/framing/break
// detection feeding a small FWFT FIFO of flagged bytes with sticky overrun.
module uart_rx_mon #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_in,
    uart_rx_mon_if.master                rd,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         overrun,
    input  logic                         ovr_clr,
    output logic                         busy
);

    localparam int unsigned TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned SUB_W  = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned STOP_W = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    typedef struct packed {
        logic       brk;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } entry_t;

    // Two-flop synchroniser; resets to the idle line level
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rxs     <= r_rx_meta;
        end
    end

    // Free-running oversample tick generator
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    state_t            r_state;
    logic [SUB_W-1:0]  r_sub;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [STOP_W-1:0] r_stop_cnt;
    logic [7:0]        r_shift;
    logic              r_par_bit;
    logic              r_ferr;
    logic              r_stop0_first;
    logic              r_need_idle;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [SUB_W-1:0]  w_sub_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [STOP_W-1:0] w_stop_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_par_nxt;
    logic              w_ferr_nxt;
    logic              w_stop0_nxt;
    logic              w_need_idle_nxt;
    logic              w_push;
    entry_t            w_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sub         <= '0;
            r_bit_cnt     <= '0;
            r_stop_cnt    <= '0;
            r_shift       <= '0;
            r_par_bit     <= 1'b0;
            r_ferr        <= 1'b0;
            r_stop0_first <= 1'b0;
            r_need_idle   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sub         <= w_sub_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_stop_cnt    <= w_stop_nxt;
            r_shift       <= w_shift_nxt;
            r_par_bit     <= w_par_nxt;
            r_ferr        <= w_ferr_nxt;
            r_stop0_first <= w_stop0_nxt;
            r_need_idle   <= w_need_idle_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    // Frame FSM: all sampling happens on tick; a bit is taken when the sub-counter hits 15
    always_comb begin
        w_state_nxt     = r_state;
        w_sub_nxt       = r_sub;
        w_bit_nxt       = r_bit_cnt;
        w_stop_nxt      = r_stop_cnt;
        w_shift_nxt     = r_shift;
        w_par_nxt       = r_par_bit;
        w_ferr_nxt      = r_ferr;
        w_stop0_nxt     = r_stop0_first;
        w_need_idle_nxt = r_need_idle;
        w_push          = 1'b0;
        w_entry         = '0;

        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    if (r_need_idle) begin
                        if (r_rxs) begin
                            w_need_idle_nxt = 1'b0;
                        end
                    end else if (!r_rxs) begin
                        w_state_nxt = S_START;
                        w_sub_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_stop_nxt  = '0;
                        w_shift_nxt = '0;
                        w_par_nxt   = 1'b0;
                        w_ferr_nxt  = 1'b0;
                        w_stop0_nxt = 1'b0;
                    end
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (r_sub == SUB_W'(7)) begin
                        w_sub_nxt   = '0;
                        w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_sub_nxt = r_sub + SUB_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    w_sub_nxt = r_sub + SUB_W'(1);
                    if (r_sub == SUB_W'(15)) begin
                        w_shift_nxt[r_bit_cnt] = r_rxs;
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = (PARITY_EN != 0) ? S_PAR : S_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end

            S_PAR: begin
                if (w_tick) begin
                    w_sub_nxt = r_sub + SUB_W'(1);
                    if (r_sub == SUB_W'(15)) begin
                        w_par_nxt   = r_rxs;
                        w_state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    w_sub_nxt = r_sub + SUB_W'(1);
                    if (r_sub == SUB_W'(15)) begin
                        w_ferr_nxt  = r_ferr | ~r_rxs;
                        w_stop0_nxt = (r_stop_cnt == '0) ? ~r_rxs : r_stop0_first;
                        if (r_stop_cnt == STOP_W'(STOP_BITS - 1)) begin
                            w_push          = 1'b1;
                            w_state_nxt     = S_IDLE;
                            w_need_idle_nxt = w_ferr_nxt;
                        end else begin
                            w_stop_nxt = r_stop_cnt + STOP_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Entry reflects the final stop sample taken this cycle
        w_entry.data = r_shift;
        w_entry.ferr = w_ferr_nxt;
        w_entry.perr = (PARITY_EN != 0) && (((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD));
        w_entry.brk  = (r_shift == '0) && ((PARITY_EN == 0) || !r_par_bit) && w_stop0_nxt;
    end

    // FIFO with registered head entry
    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_rd_valid;
    entry_t           r_head;
    logic             r_overrun;

    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic             w_ovr_set;
    logic [LVL_W-1:0] w_level_nxt;
    entry_t           w_head_nxt;

    assign w_pop     = r_rd_valid & rd.rd_ready;
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_en && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_wr_en && w_pop) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Head changes only on a push into an empty FIFO or on a pop with data behind it
    always_comb begin
        w_head_nxt = r_head;
        if (w_wr_en && (r_level == '0)) begin
            w_head_nxt = w_entry;
        end else if (w_pop) begin
            if (w_wr_en && (r_level == LVL_W'(1))) begin
                w_head_nxt = w_entry;
            end else if (r_level > LVL_W'(1)) begin
                w_head_nxt = r_mem[r_rd_ptr + PTR_W'(1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_head     <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level    <= w_level_nxt;
            r_rd_valid <= (w_level_nxt != '0);
            r_head     <= w_head_nxt;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_head.data;
    assign rd.rd_perr  = r_head.perr;
    assign rd.rd_ferr  = r_head.ferr;
    assign rd.rd_break = r_head.brk;
    assign level       = r_level;
    assign overrun     = r_overrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_mon.sv
// Directed bench for uart_rx_mon: four instances cover 8N1, 7E1, 8N2 and a 4-deep FIFO.
module tb_uart_rx_mon;

    localparam int BIT_CLK  = 64;   // 16 ticks * BAUD_DIV 4
    localparam int WAIT_MAX = 2000;

    logic       clk;
    logic       rst_n;
    logic [3:0] rx;
    logic [3:0] rdy;
    logic [3:0] clr;

    wire  [3:0]  v;
    wire  [3:0]  ovr;
    wire  [3:0]  bsy;
    wire  [10:0] head [4];
    wire  [4:0]  lvl  [4];
    wire  [4:0]  lvl0, lvl1, lvl2;
    wire  [2:0]  lvl3;

    int n_checks;
    int n_errors;

    uart_rx_mon_if if0 ();
    uart_rx_mon_if if1 ();
    uart_rx_mon_if if2 ();
    uart_rx_mon_if if3 ();

    uart_rx_mon #(.BAUD_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx[0]), .rd(if0), .level(lvl0),
        .overrun(ovr[0]), .ovr_clr(clr[0]), .busy(bsy[0]));
    uart_rx_mon #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx[1]), .rd(if1), .level(lvl1),
        .overrun(ovr[1]), .ovr_clr(clr[1]), .busy(bsy[1]));
    uart_rx_mon #(.BAUD_DIV(4), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx[2]), .rd(if2), .level(lvl2),
        .overrun(ovr[2]), .ovr_clr(clr[2]), .busy(bsy[2]));
    uart_rx_mon #(.BAUD_DIV(4), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx[3]), .rd(if3), .level(lvl3),
        .overrun(ovr[3]), .ovr_clr(clr[3]), .busy(bsy[3]));

    assign if0.rd_ready = rdy[0];
    assign if1.rd_ready = rdy[1];
    assign if2.rd_ready = rdy[2];
    assign if3.rd_ready = rdy[3];
    assign v[0] = if0.rd_valid;
    assign v[1] = if1.rd_valid;
    assign v[2] = if2.rd_valid;
    assign v[3] = if3.rd_valid;
    assign head[0] = {if0.rd_break, if0.rd_perr, if0.rd_ferr, if0.rd_data};
    assign head[1] = {if1.rd_break, if1.rd_perr, if1.rd_ferr, if1.rd_data};
    assign head[2] = {if2.rd_break, if2.rd_perr, if2.rd_ferr, if2.rd_data};
    assign head[3] = {if3.rd_break, if3.rd_perr, if3.rd_ferr, if3.rd_data};
    assign lvl[0] = lvl0;
    assign lvl[1] = lvl1;
    assign lvl[2] = lvl2;
    assign lvl[3] = {2'b00, lvl3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame bits LSB first: start, data, optional parity, stop bits
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input int db, input int pen,
                                             input logic pbit, input int sb, input logic [1:0] stopv);
        logic [15:0] f;
        int k;
        f = '1;
        f[0] = 1'b0;
        k = 1;
        for (int i = 0; i < db; i++) begin
            f[k] = d[i];
            k++;
        end
        if (pen != 0) begin
            f[k] = pbit;
            k++;
        end
        for (int i = 0; i < sb; i++) begin
            f[k] = stopv[i];
            k++;
        end
        return f;
    endfunction

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx[sel] = bits[i];
            repeat (BIT_CLK) @(posedge clk);
        end
        rx[sel] = 1'b1;
    endtask

    // Returns {break, perr, ferr, data} of the head and pops it; all X if nothing arrived
    task automatic pop_head(input int sel, output logic [10:0] got);
        bit found;
        found = 1'b0;
        got   = 'x;
        for (int i = 0; i < WAIT_MAX && !found; i++) begin
            @(negedge clk);
            if (v[sel] === 1'b1) begin
                got   = head[sel];
                found = 1'b1;
            end
        end
        if (found) begin
            rdy[sel] = 1'b1;
            @(negedge clk);
            rdy[sel] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if ({v[s], head[s], lvl[s], ovr[s], bsy[s]} !== 19'd0) begin
                n_errors++;
                $display("FAIL reset_state inst%0d: got v=%b head=%h lvl=%0d ovr=%b busy=%b, expected all 0",
                         s, v[s], head[s], lvl[s], ovr[s], bsy[s]);
            end
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        logic [10:0] cap [2];
        rdy[0] = 1'b1;
        fork
            begin
                send_bits(0, mk_frame(8'hA5, 8, 0, 1'b0, 1, 2'b11), 10);
                send_bits(0, mk_frame(8'h3C, 8, 0, 1'b0, 1, 2'b11), 10);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    bit got_one;
                    got_one = 1'b0;
                    cap[k]  = 'x;
                    for (int i = 0; i < WAIT_MAX && !got_one; i++) begin
                        @(negedge clk);
                        if (v[0] === 1'b1) begin
                            cap[k]  = head[0];
                            got_one = 1'b1;
                        end
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
        rdy[0] = 1'b0;
        n_checks++;
        if (cap[0] !== 11'h0A5) begin
            n_errors++;
            $display("FAIL 8n1_first: got %h expected %h", cap[0], 11'h0A5);
        end
        n_checks++;
        if (cap[1] !== 11'h03C) begin
            n_errors++;
            $display("FAIL 8n1_second: got %h expected %h", cap[1], 11'h03C);
        end
        n_checks++;
        if ({ovr[0], lvl[0], v[0]} !== 7'd0) begin
            n_errors++;
            $display("FAIL 8n1_drained: got ovr=%b lvl=%0d v=%b expected 0 0 0", ovr[0], lvl[0], v[0]);
        end
    endtask

    task automatic test_parity_7e1();
        logic [10:0] got;
        send_bits(1, mk_frame(8'h55, 7, 1, 1'b0, 1, 2'b11), 10);
        send_bits(1, mk_frame(8'h55, 7, 1, 1'b1, 1, 2'b11), 10);
        repeat (10) @(negedge clk);
        n_checks++;
        if (lvl[1] !== 5'd2) begin
            n_errors++;
            $display("FAIL 7e1_level: got %0d expected 2", lvl[1]);
        end
        pop_head(1, got);
        n_checks++;
        if (got !== 11'h055) begin
            n_errors++;
            $display("FAIL 7e1_good_parity: got %h expected %h", got, 11'h055);
        end
        pop_head(1, got);
        n_checks++;
        if (got !== 11'h255) begin
            n_errors++;
            $display("FAIL 7e1_bad_parity: got %h expected %h", got, 11'h255);
        end
    endtask

    task automatic test_framing_8n2();
        logic [10:0] got;
        send_bits(2, mk_frame(8'h5A, 8, 0, 1'b0, 2, 2'b01), 11);
        repeat (2 * BIT_CLK) @(posedge clk);
        send_bits(2, mk_frame(8'hC3, 8, 0, 1'b0, 2, 2'b11), 11);
        pop_head(2, got);
        n_checks++;
        if (got !== 11'h15A) begin
            n_errors++;
            $display("FAIL 8n2_stop2_low: got %h expected %h", got, 11'h15A);
        end
        pop_head(2, got);
        n_checks++;
        if (got !== 11'h0C3) begin
            n_errors++;
            $display("FAIL 8n2_clean_after: got %h expected %h", got, 11'h0C3);
        end
    endtask

    task automatic test_break();
        logic [10:0] got;
        rx[0] = 1'b0;
        repeat (20 * BIT_CLK) @(posedge clk);
        rx[0] = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_checks++;
        if (lvl[0] !== 5'd1) begin
            n_errors++;
            $display("FAIL break_single_entry: got level %0d expected 1", lvl[0]);
        end
        send_bits(0, mk_frame(8'h81, 8, 0, 1'b0, 1, 2'b11), 10);
        pop_head(0, got);
        n_checks++;
        if (got !== 11'h500) begin
            n_errors++;
            $display("FAIL break_entry: got %h expected %h", got, 11'h500);
        end
        pop_head(0, got);
        n_checks++;
        if (got !== 11'h081) begin
            n_errors++;
            $display("FAIL break_next_frame: got %h expected %h", got, 11'h081);
        end
    endtask

    task automatic test_overrun();
        logic [10:0] got;
        logic [10:0] exp;
        for (int d = 1; d <= 5; d++) begin
            send_bits(3, mk_frame(8'(d), 8, 0, 1'b0, 1, 2'b11), 10);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if ({lvl[3], ovr[3]} !== {5'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL fifo_full: got level=%0d ovr=%b expected level=4 ovr=1", lvl[3], ovr[3]);
        end
        for (int d = 1; d <= 4; d++) begin
            pop_head(3, got);
            exp = 11'(d);
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL fifo_pop%0d: got %h expected %h", d, got, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({lvl[3], v[3], ovr[3]} !== {5'd0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL fifo_empty_sticky: got level=%0d v=%b ovr=%b expected 0 0 1", lvl[3], v[3], ovr[3]);
        end
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ovr[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_clr: got %b expected 0", ovr[3]);
        end
    endtask

    task automatic test_glitch();
        rx[0] = 1'b0;
        repeat (12) @(posedge clk);
        rx[0] = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (bsy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_seen: got %b expected 1", bsy[0]);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if ({bsy[0], lvl[0], v[0]} !== 7'd0) begin
            n_errors++;
            $display("FAIL glitch_rejected: got busy=%b lvl=%0d v=%b expected 0 0 0", bsy[0], lvl[0], v[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] got;
        send_bits(0, mk_frame(8'h11, 8, 0, 1'b0, 1, 2'b11), 10);
        rx[0] = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        rx[0] = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        rx[0] = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bsy[0], lvl[0]} !== {1'b1, 5'd1}) begin
            n_errors++;
            $display("FAIL pre_reset: got busy=%b lvl=%0d expected 1 1", bsy[0], lvl[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bsy[0], lvl[0], v[0]} !== 7'd0) begin
            n_errors++;
            $display("FAIL async_reset: got busy=%b lvl=%0d v=%b expected 0 0 0", bsy[0], lvl[0], v[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_checks++;
        if (bsy[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL no_restart_on_low: got busy=%b expected 0", bsy[0]);
        end
        rx[0] = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        send_bits(0, mk_frame(8'h7E, 8, 0, 1'b0, 1, 2'b11), 10);
        pop_head(0, got);
        n_checks++;
        if (got !== 11'h07E) begin
            n_errors++;
            $display("FAIL after_reset_frame: got %h expected %h", got, 11'h07E);
        end
        @(negedge clk);
        n_checks++;
        if (lvl[0] !== 5'd0) begin
            n_errors++;
            $display("FAIL after_reset_level: got %0d expected 0", lvl[0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rx       = 4'hF;
        rdy      = 4'h0;
        clr      = 4'h0;
        test_reset();
        test_basic_8n1();
        test_parity_7e1();
        test_framing_8n2();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
